// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad by driving one column low at a time.
//   Each frame covers all four columns and yields one result: no key, a single
//   key, or a multi-key pattern. A result has to repeat for DEBOUNCE_FRAMES
//   frames in a row before it is accepted. An accepted press produces a
//   one-cycle key_valid pulse. Digit keys shift into a 4-digit BCD buffer, and
//   key F clears that buffer.
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_row    [3:0]  keypad rows, active-low, asynchronous to clk
//   key_col    [3:0]  column drive, active-low one-hot
//   key_code   [3:0]  last accepted key {row_idx, col_idx}
//   key_valid         one-cycle pulse per accepted press
//   key_held          high until the accepted key is accepted as released
//   digit_buf  [15:0] 4 BCD digits, [3:0] newest
module keypad_scanner #(
    parameter int SCAN_DIV        = 125000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digit_buf
);

    localparam int CW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DCW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]  SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DCW-1:0] DF        = DCW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {R_NONE = 2'd0, R_KEY = 2'd1, R_MULTI = 2'd2} res_kind_e;
    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } frame_res_t;

    typedef enum logic {IDLE = 1'b0, PRESSED = 1'b1} state_e;

    // The rows come from the keypad asynchronously, so they pass through a
    // two-stage synchroniser. The stages reset to "no row low".
    logic [3:0] row_meta, row_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    // Slot timing and column rotation
    logic [CW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic          slot_end;

    assign slot_end = (slot_cnt == SLOT_LAST);
    assign key_col  = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    // Merge the sample for the current column into the running frame result.
    // The frame holds a single key only when exactly one column showed
    // exactly one low row. Any other non-empty pattern is MULTI.
    logic [3:0] rows_low;
    logic       row_onehot;
    logic [1:0] row_idx;
    frame_res_t acc, merged;

    assign rows_low   = ~row_sync;
    assign row_onehot = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'h1)) == 4'h0);

    always_comb begin
        row_idx = 2'd0;
        for (int r = 3; r >= 0; r--)
            if (rows_low[r]) row_idx = 2'(r);
    end

    always_comb begin
        merged = acc;
        if (rows_low != 4'h0) begin
            if (row_onehot && acc.kind == R_NONE) begin
                merged.kind = R_KEY;
                merged.code = {row_idx, col_idx};
            end else begin
                merged.kind = R_MULTI;
                merged.code = 4'h0;
            end
        end
    end

    logic frame_end;
    assign frame_end = slot_end && (col_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '{kind: R_NONE, code: 4'h0};
        end else if (slot_end) begin
            acc <= frame_end ? '{kind: R_NONE, code: 4'h0} : merged;
        end
    end

    // Debounce. The count saturates at DF, so acceptance fires once, on the
    // frame where the count reaches DF. It does not fire again while the
    // same result keeps repeating.
    frame_res_t     prev_res;
    logic [DCW-1:0] deb_cnt, deb_cnt_nxt;
    logic           accept;

    always_comb begin
        if (merged == prev_res)
            deb_cnt_nxt = (deb_cnt == DF) ? DF : deb_cnt + DCW'(1);
        else
            deb_cnt_nxt = DCW'(1);
    end

    assign accept = frame_end && (deb_cnt_nxt == DF) && (deb_cnt != DF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_res <= '{kind: R_NONE, code: 4'h0};
            deb_cnt  <= '0;
        end else if (frame_end) begin
            prev_res <= merged;
            deb_cnt  <= deb_cnt_nxt;
        end
    end

    // Press/release FSM. The FSM reacts to a new key only from IDLE, so
    // there is no auto-repeat. A key can be pressed again only after the
    // release has been accepted.
    state_e state, state_nxt;
    logic   press_evt;

    always_comb begin
        state_nxt = state;
        press_evt = 1'b0;
        case (state)
            IDLE:
                if (accept && merged.kind == R_KEY) begin
                    state_nxt = PRESSED;
                    press_evt = 1'b1;
                end
            PRESSED:
                if (accept && merged.kind == R_NONE)
                    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            digit_buf <= 16'h0000;
        end else begin
            state     <= state_nxt;
            key_valid <= press_evt;
            if (press_evt) begin
                key_code <= merged.code;
                if (merged.code <= 4'd9)
                    digit_buf <= {digit_buf[11:0], merged.code};
                else if (merged.code == 4'hF)
                    digit_buf <= 16'h0000;
            end
        end
    end

    assign key_held = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed test of keypad_scanner with SCAN_DIV=4 and DEBOUNCE_FRAMES=3,
//   so one frame is 16 clocks. A small matrix model pulls a row low when
//   the key at that row/column is pressed and its column is being driven.
//   The bench always changes stimulus on frame boundaries. That lets the
//   cycle of each expected pulse be worked out by hand.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digit_buf;

    logic [15:0] pressed = 16'h0;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned pulses = 0;
    int unsigned last_pulse_cyc = 0;
    int unsigned cyc;
    int unsigned p0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digit_buf (digit_buf)
    );

    always #5 clk = ~clk;

    // Keypad matrix model. Bit r*4+c of pressed stands for key code r*4+c.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    // Cycle index since reset release. It equals the DUT slot position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses         = pulses + 1;
            last_pulse_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_col",   key_col,   4'b1110);
        chk("rst_code",  key_code,  4'h0);
        chk("rst_vld",   key_valid, 1'b0);
        chk("rst_held",  key_held,  1'b0);
        chk("rst_buf",   digit_buf, 16'h0000);
        rst_n = 1'b1;

        // 1: column rotation with no keys pressed
        for (int k = 0; k < 16; k++) begin
            chk("t1_col", key_col, ~(32'd1 << (k / 4)) & 32'hF);
            chk("t1_vld", key_valid, 1'b0);
            @(negedge clk);
        end

        // 2: hold code 6 from the start of frame 1. The third KEY frame
        //    ends at cycle 63, so the pulse is seen in cycle 64.
        pressed = 16'h1 << 6;
        frames(4);
        chk("t2_pulses", pulses, 1);
        chk("t2_cyc",    last_pulse_cyc, 64);
        chk("t2_code",   key_code, 4'h6);
        chk("t2_held",   key_held, 1'b1);
        chk("t2_buf",    digit_buf, 16'h0006);
        frames(2);
        chk("t2_norpt",  pulses, 1);
        pressed = 16'h0;
        frames(4);
        chk("t2_rel",    key_held, 1'b0);

        // 3: keys 1..5, each with a clean release
        for (int d = 1; d <= 5; d++) begin
            pressed = 16'h1 << d;
            frames(4);
            chk("t3_code", key_code, d);
            pressed = 16'h0;
            frames(4);
        end
        chk("t3_pulses", pulses, 6);
        chk("t3_buf",    digit_buf, 16'h2345);

        // 4: key 7 bouncing for 6 frames, then held steady
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? (16'h1 << 7) : 16'h0;
            frames(1);
        end
        pressed = 16'h1 << 7;
        frames(2);
        chk("t4_early",  pulses, p0);
        frames(1);
        chk("t4_vld",    key_valid, 1'b1);
        frames(2);
        chk("t4_pulses", pulses, p0 + 1);
        chk("t4_buf",    digit_buf, 16'h3457);
        pressed = 16'h0;
        frames(4);

        // 5: codes 6 and 9 pressed together give MULTI, which is ignored.
        //    Key F then clears the buffer.
        p0 = pulses;
        pressed = (16'h1 << 6) | (16'h1 << 9);
        frames(5);
        chk("t5_multi",  pulses, p0);
        chk("t5_mheld",  key_held, 1'b0);
        pressed = 16'h1 << 15;
        frames(4);
        chk("t5_pulses", pulses, p0 + 1);
        chk("t5_code",   key_code, 4'hF);
        chk("t5_buf",    digit_buf, 16'h0000);
        pressed = 16'h0;
        frames(4);

        // 6: reset asserted while key 2 is held. After release the key must
        //    debounce again, and the pulse is seen in cycle 48.
        pressed = 16'h1 << 2;
        frames(4);
        chk("t6_held0",  key_held, 1'b1);
        chk("t6_buf0",   digit_buf, 16'h0002);
        p0 = pulses;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_col",    key_col, 4'b1110);
        chk("t6_code",   key_code, 4'h0);
        chk("t6_held",   key_held, 1'b0);
        chk("t6_buf",    digit_buf, 16'h0000);
        chk("t6_vld",    key_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        frames(4);
        chk("t6_pulses", pulses, p0 + 1);
        chk("t6_cyc",    last_pulse_cyc, 48);
        chk("t6_code2",  key_code, 4'h2);
        chk("t6_buf2",   digit_buf, 16'h0002);
        chk("t6_held2",  key_held, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
